// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: condition codes, flag bit positions and FSM states.
// Imported by pc_sequencer and pc_ras.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      COND_NE = 3'b000,
      COND_EQ = 3'b001,
      COND_GT = 3'b010,
      COND_LT = 3'b011,
      COND_GE = 3'b100,
      COND_LE = 3'b101,
      COND_OV = 3'b110,
      COND_AL = 3'b111
   } cond_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
      logic z;
      logic n;
      logic v;
      logic res;
      z = flags[FLAG_Z];
      n = flags[FLAG_N];
      v = flags[FLAG_V];
      case (cond_e'(cond))
         COND_NE: res = ~z;
         COND_EQ: res = z;
         COND_GT: res = ~z & ~n;
         COND_LT: res = n;
         COND_GE: res = z | ~n;
         COND_LE: res = z | n;
         COND_OV: res = v;
         default: res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full silently overwrites the oldest entry.
// Caller guarantees push and pop are never asserted together.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            full,
   output logic            empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;

   assign top   = mem[wr_ptr - PTR_ONE];
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // Only pointer and count are reset; stale entries are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_ONE;
         if (!full) count <= count + CNT_ONE;
      end else if (pop && !empty) begin
         wr_ptr <= wr_ptr - PTR_ONE;
         count  <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with conditional/register branches, call/return and halt.
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
//
// state   | meaning
// ST_RUN  | pc advances each unstalled cycle
// ST_HALT | pc frozen at halt address, left only by rst
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W      = 16,
   parameter int              IMM_W     = 9,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic             branch_reg,
   input  logic             call,
   input  logic             ret,
   input  logic             halt,
   input  logic [2:0]       cond,
   input  logic [2:0]       flags,
   input  logic [IMM_W-1:0] imm,
   input  logic [PC_W-1:0]  reg_target,
   output logic [PC_W-1:0]  pc,
   output logic             taken,
   output logic             halted,
   output logic             ras_full,
   output logic             ras_empty,
   output logic             ras_err
);

`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   state_e          state_q;
   state_e          state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] seq;
   logic [PC_W-1:0] rel;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] ras_top;
   logic            ras_full_w;
   logic            ras_empty_w;
   logic            push;
   logic            pop;
   logic            err_d;
   logic            ras_err_q;

   assign imm_ext = {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
   assign seq     = pc_q + PC_W'(2);
   assign rel     = seq + (imm_ext << 1);
   assign target  = branch_reg ? reg_target : rel;

`ifdef PC_SEQ_RAS_EN
   pc_ras #(
      .PC_W  (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (seq),
      .top       (ras_top),
      .full      (ras_full_w),
      .empty     (ras_empty_w)
   );
`else
   logic unused_ras;
   assign ras_top     = '0;
   assign ras_full_w  = 1'b0;
   assign ras_empty_w = 1'b1;
   assign unused_ras  = ^{push, pop, RAS_DEPTH[0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_PC;
         ras_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ras_err_q <= err_d;
      end
   end

   // Priority: halt > ret > call > taken branch > sequential.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      taken   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      err_d   = 1'b0;
      if (!stall && state_q == ST_RUN) begin
         if (halt) begin
            state_d = ST_HALT;
         end else if (ret) begin
            if (!ras_empty_w) begin
               pop   = 1'b1;
               pc_d  = ras_top;
               taken = 1'b1;
            end else begin
               pc_d  = seq;
               err_d = RAS_ON;
            end
         end else if (call) begin
            pc_d  = target;
            taken = 1'b1;
            push  = RAS_ON;
            err_d = ras_full_w;
         end else if ((branch || branch_reg) && cond_true(cond, flags)) begin
            pc_d  = target;
            taken = 1'b1;
         end else begin
            pc_d = seq;
         end
      end
   end

   assign pc        = pc_q;
   assign halted    = (state_q == ST_HALT);
   assign ras_full  = ras_full_w;
   assign ras_empty = ras_empty_w;
   assign ras_err   = ras_err_q & ~stall;

endmodule
